// File: rtl/nl2_excl_pkg.sv
// rtl/nl2_excl_pkg.sv - shared encodings and entry types for the exclusive-access monitor
package nl2_excl_pkg;

  localparam logic [1:0] EXCL_PASS = 2'b00;
  localparam logic [1:0] EXCL_FAIL = 2'b10;

  // Storage is sized for the widest supported configuration; unused upper bits stay zero.
  localparam int EXCL_ID_MAX   = 16;
  localparam int EXCL_GRAN_MAX = 64;

  typedef logic [EXCL_ID_MAX-1:0]   excl_id_t;
  typedef logic [EXCL_GRAN_MAX-1:0] excl_gran_t;

  typedef struct packed {
    logic       valid;
    excl_id_t   id;
    excl_gran_t granule;
  } excl_entry_t;

  typedef struct packed {
    logic       valid;
    logic       lock;
    logic       pass;
    excl_gran_t granule;
  } excl_aw_t;

endpackage

// File: rtl/nl2_excl_mon_entry.sv
// rtl/nl2_excl_mon_entry.sv - one reservation entry: storage, compare, set/clear
module nl2_excl_mon_entry
  import nl2_excl_pkg::*;
(
  input  logic       axi_clk,
  input  logic       rst_a,
  input  logic       set,
  input  excl_id_t   set_id,
  input  excl_gran_t set_gran,
  input  logic       clr,
  input  excl_gran_t clr_gran,
  input  excl_id_t   cmp_id,
  input  excl_gran_t cmp_gran,
  output logic       valid,
  output logic       clr_hit,
  output logic       id_hit,
  output logic       excl_hit
);

  excl_entry_t ent;

  assign valid    = ent.valid;
  assign clr_hit  = clr && ent.valid && (ent.granule == clr_gran);
  // An entry being cleared this cycle no longer owns its ID for allocation.
  assign id_hit   = ent.valid && !clr_hit && (ent.id == set_id);
  assign excl_hit = ent.valid && (ent.id == cmp_id) && (ent.granule == cmp_gran);

  always_ff @(posedge axi_clk or posedge rst_a) begin
    if (rst_a) begin
      ent <= '0;
    end else if (set) begin
      ent.valid   <= 1'b1;
      ent.id      <= set_id;
      ent.granule <= set_gran;
    end else if (clr_hit) begin
      ent.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nl2_dbank_mexcl_monitor.sv
// rtl/nl2_dbank_mexcl_monitor.sv - AXI exclusive-access monitor with victim-pointer eviction
module nl2_dbank_mexcl_monitor
  import nl2_excl_pkg::*;
#(
  parameter int NUM_MON       = 4,
  parameter int CMD_ID_SIZE   = 4,
  parameter int WR_ID_SIZE    = 4,
  parameter int CMD_ADDR_SIZE = 32,
  parameter int GRAN_LSB      = 7
) (
  input  logic                     axi_clk,
  input  logic                     rst_a,
  input  logic                     axi_arvalid,
  input  logic                     axi_arready,
  input  logic                     axi_arlock,
  input  logic [CMD_ID_SIZE-1:0]   axi_arid,
  input  logic [CMD_ADDR_SIZE-1:0] axi_araddr,
  input  logic                     axi_awvalid,
  input  logic                     axi_awready,
  input  logic                     axi_awlock,
  input  logic [WR_ID_SIZE-1:0]    axi_awid,
  input  logic [CMD_ADDR_SIZE-1:0] axi_awaddr,
  output logic [1:0]               excl_err,
  output logic [NUM_MON-1:0]       mon_valid,
  output logic                     mon_evict
);

  localparam int VW = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;

  excl_id_t   ar_id, aw_id;
  excl_gran_t ar_gran, aw_gran;
  excl_aw_t   aw_r;
  logic       ar_excl, clr_en, evict_now, found;
  logic [VW-1:0]      vptr;
  logic [NUM_MON-1:0] ent_valid, clr_hit, id_hit, excl_hit, alloc_sel, set_vec;
  logic               unused_addr_lsbs;

  assign ar_id   = excl_id_t'(axi_arid);
  assign aw_id   = excl_id_t'(axi_awid);
  assign ar_gran = excl_gran_t'(axi_araddr[CMD_ADDR_SIZE-1:GRAN_LSB]);
  assign aw_gran = excl_gran_t'(axi_awaddr[CMD_ADDR_SIZE-1:GRAN_LSB]);
  assign unused_addr_lsbs = ^{axi_araddr[GRAN_LSB-1:0], axi_awaddr[GRAN_LSB-1:0]};

  assign ar_excl   = axi_arvalid && axi_arready && axi_arlock;
  assign clr_en    = aw_r.valid && (!aw_r.lock || aw_r.pass);
  assign mon_valid = ent_valid;
  assign set_vec   = alloc_sel & {NUM_MON{ar_excl}};

  for (genvar g = 0; g < NUM_MON; g++) begin : g_ent
    nl2_excl_mon_entry u_ent (
      .axi_clk  (axi_clk),
      .rst_a    (rst_a),
      .set      (set_vec[g]),
      .set_id   (ar_id),
      .set_gran (ar_gran),
      .clr      (clr_en),
      .clr_gran (aw_r.granule),
      .cmp_id   (aw_id),
      .cmp_gran (aw_gran),
      .valid    (ent_valid[g]),
      .clr_hit  (clr_hit[g]),
      .id_hit   (id_hit[g]),
      .excl_hit (excl_hit[g])
    );
  end

  // Target priority: same-ID entry, then lowest free (clears count as free), then victim.
  always_comb begin
    alloc_sel = '0;
    evict_now = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < NUM_MON; i++) begin
      if (!found && id_hit[i]) begin
        alloc_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MON; i++) begin
      if (!found && !(ent_valid[i] && !clr_hit[i])) begin
        alloc_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
    if (!found) begin
      alloc_sel[vptr] = 1'b1;
      evict_now       = 1'b1;
    end
  end

  always_comb begin
    excl_err = EXCL_PASS;
    if (!rst_a && axi_awvalid && axi_awlock && !(|excl_hit))
      excl_err = EXCL_FAIL;
  end

  always_ff @(posedge axi_clk or posedge rst_a) begin
    if (rst_a) begin
      vptr      <= '0;
      mon_evict <= 1'b0;
      aw_r      <= '0;
    end else begin
      mon_evict <= ar_excl && evict_now;
      if (ar_excl && evict_now)
        vptr <= (vptr == VW'(NUM_MON-1)) ? '0 : vptr + 1'b1;
      aw_r.valid   <= axi_awvalid && axi_awready;
      aw_r.lock    <= axi_awlock;
      aw_r.pass    <= (excl_err == EXCL_PASS);
      aw_r.granule <= aw_gran;
    end
  end

endmodule

// File: doc/nl2_dbank_mexcl_monitor.md
NL2_DBANK_MEXCL_MONITOR -- requirements
Module: nl2_dbank_mexcl_monitor

Interface
REQ-001 SHALL have parameter NUM_MON, default 4, meaning number of monitor entries (legal 1..16).
REQ-002 SHALL have parameter CMD_ID_SIZE, default 4, meaning read ID width (legal >= 1).
REQ-003 SHALL have parameter WR_ID_SIZE, default 4, meaning write ID width (legal 1..CMD_ID_SIZE).
REQ-004 SHALL have parameter CMD_ADDR_SIZE, default 32, meaning address width (legal > GRAN_LSB).
REQ-005 SHALL have parameter GRAN_LSB, default 7, meaning log2 of the reservation granule in bytes.
REQ-006 SHALL have port axi_clk, input, 1 bit, clock; reset rst_a, asynchronous, active-high; clock axi_clk.
REQ-007 SHALL have port rst_a, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have ports axi_arvalid, axi_arready and axi_arlock, inputs, 1 bit each; axi_arid, input, CMD_ID_SIZE; axi_araddr, input, CMD_ADDR_SIZE; together these form the read command handshake.
REQ-009 SHALL have ports axi_awvalid, axi_awready and axi_awlock, inputs, 1 bit each; axi_awid, input, WR_ID_SIZE; axi_awaddr, input, CMD_ADDR_SIZE; together these form the write command handshake.
REQ-010 SHALL have port excl_err, output, 2 bits; 2'b00 means pass or non-exclusive, 2'b10 means exclusive fail.
REQ-011 SHALL have port mon_valid, output, NUM_MON bits, giving per-entry valid status.
REQ-012 SHALL have port mon_evict, output, 1 bit, a one-cycle pulse when a valid entry is overwritten.

Function
REQ-013 SHALL record an exclusive read when arvalid&&arready&&arlock; the entry stores the ID and araddr[CMD_ADDR_SIZE-1:GRAN_LSB].
REQ-014 SHALL choose the allocation target in this priority order: (1) a valid entry with the same ID, which is overwritten with no evict; (2) the lowest-index free entry; (3) the entry at victim pointer vptr, with mon_evict=1 in the following cycle.
REQ-015 SHALL increment vptr modulo NUM_MON on every eviction, and hold it otherwise.
REQ-016 SHALL make an entry valid starting from the cycle after the exclusive-read acceptance.
REQ-017 SHALL define an ID match as the full stored ID equal to awid zero-extended to CMD_ID_SIZE, so stored MSBs above WR_ID_SIZE must be zero.
REQ-018 SHALL drive excl_err combinationally: if awvalid&&awlock and any valid entry matches both ID and granule address, then 2'b00; if awvalid&&awlock and no such entry, then 2'b10; otherwise 2'b00.
REQ-019 SHALL register each accepted write (awvalid&&awready) as aw_r: valid, lock, ID, granule, and pass/fail.
REQ-020 SHALL, when aw_r is valid, clear every valid entry whose granule equals aw_r granule, if the write was non-exclusive or a passing exclusive; entries are invalid from the second cycle after write acceptance.
REQ-021 SHALL NOT clear any entry on a failed exclusive write.
REQ-022 SHALL treat a clear that targets the same entry as an allocation in the same cycle as follows: the allocation wins and the entry is valid with the new contents.
REQ-023 SHALL apply clear before allocation in the same cycle, so an entry freed by a clear is eligible as a free slot.
REQ-024 SHALL ignore arlock when arready=0; a pending exclusive read does not allocate.
REQ-025 SHALL use NUM_MON=1 as a degenerate case that behaves as a single-entry monitor with every conflict an eviction.

Reset
REQ-026 SHALL, while rst_a is asserted, force all entries invalid, stored ID/address to 0, vptr=0, aw_r valid=0, mon_valid=0, mon_evict=0 and excl_err=2'b00.
REQ-027 SHALL discard all reservations when rst_a is asserted mid-operation; the first exclusive write after release returns 2'b10.

Structure
REQ-028 SHALL define the excl_err encodings (EXCL_PASS=2'b00, EXCL_FAIL=2'b10) and the entry struct typedef (valid, id, granule) in the shared package nl2_excl_pkg.
REQ-029 SHALL implement each entry as one sub-module nl2_excl_mon_entry (storage, match compare, set/clear), instanced NUM_MON times; allocation, victim pointer and write capture stay at top level.

Verification
REQ-030 SHALL cover: exclusive read ID=3, addr=0x1000; then exclusive write ID=3, addr=0x1040 -> excl_err=2'b00; entry 0 cleared two cycles after acceptance.
REQ-031 SHALL cover: exclusive read ID=3, addr=0x1000; then plain write ID=5, addr=0x1010 -> entry cleared; a subsequent exclusive write ID=3, addr=0x1000 -> excl_err=2'b10.
REQ-032 SHALL cover, with NUM_MON=4: exclusive reads with IDs 0,1,2,3,4 to distinct granules -> IDs 0..3 fill entries 0..3; ID 4 evicts entry 0, mon_evict pulses, vptr=1; an exclusive write for ID 0 -> 2'b10.
REQ-033 SHALL cover, with CMD_ID_SIZE=6 and WR_ID_SIZE=4: exclusive read ID=0x13, addr=0x2000; exclusive write ID=0x3, addr=0x2000 -> 2'b10.
REQ-034 SHALL cover: an exclusive read ID=1, addr=0x3000 accepted in the same cycle that the registered plain write to 0x3000 clears -> entry valid afterwards; exclusive write ID=1 -> 2'b00.
REQ-035 SHALL cover: rst_a asserted for 1 cycle with 4 valid entries -> mon_valid=0; exclusive write to any recorded ID/address -> 2'b10.
